// File: rtl/t05_stage_sequencer.sv
// ---------------------------------------------------------------------------
// t05_stage_sequencer
//
// Top-level sequencer for the team_05 compression pipeline. It walks the
// pipeline stages in order: each stage receives a one-cycle start pulse,
// then the sequencer waits for that stage's done (or error) before moving on.
// A single loop-back edge lets stage LOOP_FROM hand control back to stage
// LOOP_TO (e.g. tree build re-entering find-least-value) up to LOOP_MAX times.
//
// Optional feature: define T05_STAGE_WATCHDOG_EN to add a per-stage watchdog
// that forces ERROR (and raises timeout) when a stage stalls too long.
// Without it, a stalled stage waits forever and timeout is tied low.
//
// Ports:
//   clk             system clock
//   nrst            synchronous active-low reset
//   cont_en         start request, only honoured in IDLE
//   restart_en      abort/restart request, honoured in every state
//   stage_done      per-stage done (level or pulse), active stage bit only
//   stage_err       per-stage error, active stage bit only
//   loop_req        qualifies a done of stage LOOP_FROM as a loop-back
//   stage_start     one-hot, one-cycle start pulse
//   stage_busy      one-hot, high while the stage is active
//   state_reg       0=IDLE, k+1=RUN stage k, NUM_STAGES+1=DONE, all-ones=ERROR
//   finished_signal high in DONE
//   error           high in ERROR (sticky until restart/reset)
//   err_stage       index of the faulting stage, valid while error=1
//   loop_count      loop-backs taken in the current run (saturating)
//   timeout         watchdog expiry flag (always 0 without the watchdog)
// ---------------------------------------------------------------------------
module t05_stage_sequencer #(
  parameter int NUM_STAGES = 7,
  parameter int STATE_W    = 4,
  parameter int LOOP_FROM  = 3,
  parameter int LOOP_TO    = 1,
  parameter int LOOP_MAX   = 255,
  parameter int TIMEOUT_W  = 20
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  cont_en,
  input  logic                  restart_en,
  input  logic [NUM_STAGES-1:0] stage_done,
  input  logic [NUM_STAGES-1:0] stage_err,
  input  logic                  loop_req,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic [NUM_STAGES-1:0] stage_busy,
  output logic [STATE_W-1:0]    state_reg,
  output logic                  finished_signal,
  output logic                  error,
  output logic [STATE_W-1:0]    err_stage,
  output logic [7:0]            loop_count,
  output logic                  timeout
);

  // Reject parameter sets the encoding cannot represent.
  if (NUM_STAGES < 2 || NUM_STAGES > 14 || (1 << STATE_W) < NUM_STAGES + 3 ||
      LOOP_TO > LOOP_FROM || LOOP_FROM >= NUM_STAGES || LOOP_MAX > 255 ||
      TIMEOUT_W < 2) begin : g_param_check
    $error("t05_stage_sequencer: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERROR} mode_t;

  mode_t                 mode_q, mode_d;
  logic [STATE_W-1:0]    stage_q, stage_d;
  logic [NUM_STAGES-1:0] start_d, busy_d;
  logic [STATE_W-1:0]    state_reg_d, err_stage_d;
  logic                  finished_d, error_d;
  logic [7:0]            loop_count_d;
  logic                  entry_cycle, done_hit, err_hit, wd_hit;

  function automatic logic [NUM_STAGES-1:0] stage_onehot(input logic [STATE_W-1:0] idx);
    logic [NUM_STAGES-1:0] one;
    one = {{(NUM_STAGES-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  // The registered start pulse marks the entry cycle; stage_busy is the
  // one-hot of the active stage, so masking with it picks out that stage's
  // done/err bit without a variable index.
  assign entry_cycle = |stage_start;
  assign done_hit    = |(stage_done & stage_busy);
  assign err_hit     = |(stage_err & stage_busy);

`ifdef T05_STAGE_WATCHDOG_EN
  logic [TIMEOUT_W-1:0] wd_q, wd_d, wd_inc;
  logic                 timeout_d;

  // The counter is zero on a stage's entry cycle and counts every RUN cycle;
  // the timeout fires on the edge where it would reach all-ones.
  assign wd_inc = wd_q + TIMEOUT_W'(1);
  assign wd_hit = (mode_q == S_RUN) && (&wd_inc);

  always_comb begin
    wd_d      = '0;
    timeout_d = timeout;
    if (|start_d) begin
      wd_d = '0;
    end else if (mode_q == S_RUN) begin
      wd_d = wd_inc;
    end
    if (restart_en) begin
      timeout_d = 1'b0;
    end else if (wd_hit) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wd_q    <= '0;
      timeout <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      timeout <= timeout_d;
    end
  end
`else
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  // Next-state and next-output logic. Every output is computed here and
  // registered below, so all outputs come straight from flops.
  always_comb begin
    mode_d       = mode_q;
    stage_d      = stage_q;
    start_d      = '0;
    busy_d       = stage_busy;
    finished_d   = finished_signal;
    error_d      = error;
    err_stage_d  = err_stage;
    loop_count_d = loop_count;

    if (restart_en) begin
      // Restart always lands in IDLE first; a simultaneous cont_en is dropped.
      mode_d       = S_IDLE;
      stage_d      = '0;
      busy_d       = '0;
      finished_d   = 1'b0;
      error_d      = 1'b0;
      err_stage_d  = '0;
      loop_count_d = '0;
    end else begin
      case (mode_q)
        S_IDLE: begin
          loop_count_d = '0;
          if (cont_en) begin
            mode_d  = S_RUN;
            stage_d = '0;
            start_d = stage_onehot('0);
            busy_d  = stage_onehot('0);
          end
        end
        S_RUN: begin
          if (wd_hit) begin
            mode_d      = S_ERROR;
            busy_d      = '0;
            error_d     = 1'b1;
            err_stage_d = stage_q;
          end else if (!entry_cycle) begin
            // Inputs are ignored on the entry cycle so a done level left over
            // from the previous stage cannot skip this one.
            if (err_hit) begin
              mode_d      = S_ERROR;
              busy_d      = '0;
              error_d     = 1'b1;
              err_stage_d = stage_q;
            end else if (done_hit) begin
              if (stage_q == STATE_W'(LOOP_FROM) && loop_req) begin
                if (loop_count < 8'(LOOP_MAX)) begin
                  stage_d      = STATE_W'(LOOP_TO);
                  start_d      = stage_onehot(STATE_W'(LOOP_TO));
                  busy_d       = stage_onehot(STATE_W'(LOOP_TO));
                  loop_count_d = loop_count + 8'd1;
                end else begin
                  mode_d      = S_ERROR;
                  busy_d      = '0;
                  error_d     = 1'b1;
                  err_stage_d = stage_q;
                end
              end else if (stage_q == STATE_W'(NUM_STAGES - 1)) begin
                mode_d     = S_DONE;
                busy_d     = '0;
                finished_d = 1'b1;
              end else begin
                stage_d = stage_q + STATE_W'(1);
                start_d = stage_onehot(stage_q + STATE_W'(1));
                busy_d  = stage_onehot(stage_q + STATE_W'(1));
              end
            end
          end
        end
        S_DONE: begin
          finished_d = 1'b1;
          busy_d     = '0;
        end
        S_ERROR: begin
          error_d = 1'b1;
          busy_d  = '0;
        end
        default: begin
          mode_d = S_IDLE;
          busy_d = '0;
        end
      endcase
    end

    case (mode_d)
      S_IDLE:  state_reg_d = '0;
      S_RUN:   state_reg_d = stage_d + STATE_W'(1);
      S_DONE:  state_reg_d = STATE_W'(NUM_STAGES + 1);
      default: state_reg_d = '1;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      mode_q          <= S_IDLE;
      stage_q         <= '0;
      stage_start     <= '0;
      stage_busy      <= '0;
      state_reg       <= '0;
      finished_signal <= 1'b0;
      error           <= 1'b0;
      err_stage       <= '0;
      loop_count      <= '0;
    end else begin
      mode_q          <= mode_d;
      stage_q         <= stage_d;
      stage_start     <= start_d;
      stage_busy      <= busy_d;
      state_reg       <= state_reg_d;
      finished_signal <= finished_d;
      error           <= error_d;
      err_stage       <= err_stage_d;
      loop_count      <= loop_count_d;
    end
  end

endmodule

// File: tb/tb_t05_stage_sequencer.sv
// ---------------------------------------------------------------------------
// tb_t05_stage_sequencer
//
// Directed bench for t05_stage_sequencer with default parameters (7 stages,
// loop 3->1, LOOP_MAX=255, watchdog not compiled in). Expected values are
// hand-derived; start pulses are logged on the falling edge and compared
// against the expected stage order.
// ---------------------------------------------------------------------------
module tb_t05_stage_sequencer;

  localparam int N  = 7;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          nrst, cont_en, restart_en, loop_req;
  logic [N-1:0]  stage_done, stage_err, stage_start, stage_busy;
  logic [SW-1:0] state_reg, err_stage;
  logic          finished_signal, error, timeout;
  logic [7:0]    loop_count;

  int checks   = 0;
  int failures = 0;
  int pulse_log[$];

  t05_stage_sequencer #(
    .NUM_STAGES(N), .STATE_W(SW), .LOOP_FROM(3), .LOOP_TO(1),
    .LOOP_MAX(255), .TIMEOUT_W(20)
  ) dut (
    .clk(clk), .nrst(nrst), .cont_en(cont_en), .restart_en(restart_en),
    .stage_done(stage_done), .stage_err(stage_err), .loop_req(loop_req),
    .stage_start(stage_start), .stage_busy(stage_busy), .state_reg(state_reg),
    .finished_signal(finished_signal), .error(error), .err_stage(err_stage),
    .loop_count(loop_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Log the stage index of every cycle that carries a start pulse; a
  // non-one-hot pulse is logged as 99.
  always @(negedge clk) begin
    if (stage_start != '0) begin
      int idx;
      idx = 99;
      if ($onehot(stage_start)) begin
        for (int b = 0; b < N; b++) if (stage_start[b]) idx = b;
      end
      pulse_log.push_back(idx);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic c, input logic r, input logic [N-1:0] d,
                               input logic [N-1:0] e, input logic l);
    cont_en    = c;
    restart_en = r;
    stage_done = d;
    stage_err  = e;
    loop_req   = l;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the entry cycle of stage k.
  task automatic enterCheck(input string tag, input int k);
    checkOutput({tag, "_state"}, 32'(state_reg), 32'(k + 1));
    checkOutput({tag, "_start"}, 32'(stage_start), 32'(1) << k);
    checkOutput({tag, "_busy"}, 32'(stage_busy), 32'(1) << k);
  endtask

  // Stage k was just entered: wait one cycle, then give it a one-cycle done.
  task automatic ackStage(input int k, input logic lr);
    tick();
    applyStimulus(1'b0, 1'b0, N'(1) << k, '0, lr);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic doRestart();
    applyStimulus(1'b0, 1'b1, '0, '0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic doStart();
    pulse_log.delete();
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    int seq[13];
    int threes;

    // Reset with every other input active.
    nrst = 1'b0;
    applyStimulus(1'b1, 1'b1, '1, '1, 1'b1);
    tick();
    tick();
    checkOutput("rst_state", 32'(state_reg), 32'd0);
    checkOutput("rst_start", 32'(stage_start), 32'd0);
    checkOutput("rst_busy", 32'(stage_busy), 32'd0);
    checkOutput("rst_finished", 32'(finished_signal), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_err_stage", 32'(err_stage), 32'd0);
    checkOutput("rst_loop_count", 32'(loop_count), 32'd0);
    checkOutput("rst_timeout", 32'(timeout), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    nrst = 1'b1;
    tick();
    checkOutput("idle_hold_state", 32'(state_reg), 32'd0);

    // Straight run, each done arriving 3 cycles after its start pulse.
    $display("[TB] straight run");
    doStart();
    for (int k = 0; k < N; k++) begin
      enterCheck("straight", k);
      tick();
      checkOutput("straight_pulse_width", 32'(stage_start), 32'd0);
      tick();
      tick();
      checkOutput("straight_not_finished", 32'(finished_signal), 32'd0);
      applyStimulus(1'b0, 1'b0, N'(1) << k, '0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    end
    checkOutput("straight_done_state", 32'(state_reg), 32'd8);
    checkOutput("straight_finished", 32'(finished_signal), 32'd1);
    checkOutput("straight_done_busy", 32'(stage_busy), 32'd0);
    checkOutput("straight_pulse_count", 32'(pulse_log.size()), 32'd7);
    for (int i = 0; i < 7 && i < pulse_log.size(); i++)
      checkOutput("straight_pulse_order", 32'(pulse_log[i]), 32'(i));

    // DONE ignores cont_en and holds.
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("done_hold_state", 32'(state_reg), 32'd8);
    checkOutput("done_hold_start", 32'(stage_start), 32'd0);
    doRestart();
    checkOutput("done_restart_state", 32'(state_reg), 32'd0);
    checkOutput("done_restart_finished", 32'(finished_signal), 32'd0);

    // cont_en together with restart_en in IDLE stays in IDLE.
    applyStimulus(1'b1, 1'b1, '0, '0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("idle_both_state", 32'(state_reg), 32'd0);
    checkOutput("idle_both_start", 32'(stage_start), 32'd0);

    // Loop-back twice through stage 3, then continue to DONE.
    $display("[TB] loop-back run");
    seq = '{0, 1, 2, 3, 1, 2, 3, 1, 2, 3, 4, 5, 6};
    threes = 0;
    doStart();
    for (int i = 0; i < 13; i++) begin
      logic lr;
      checkOutput("loop_state", 32'(state_reg), 32'(seq[i] + 1));
      lr = (seq[i] == 3) && (threes < 2);
      if (seq[i] == 3) threes++;
      ackStage(seq[i], lr);
    end
    checkOutput("loop_done_state", 32'(state_reg), 32'd8);
    checkOutput("loop_count_final", 32'(loop_count), 32'd2);
    checkOutput("loop_finished", 32'(finished_signal), 32'd1);
    checkOutput("loop_pulse_count", 32'(pulse_log.size()), 32'd13);
    for (int i = 0; i < 13 && i < pulse_log.size(); i++)
      checkOutput("loop_pulse_order", 32'(pulse_log[i]), 32'(seq[i]));
    doRestart();
    checkOutput("loop_restart_count", 32'(loop_count), 32'd0);

    // stage_err[4] together with stage_done[4]: error wins and is sticky.
    $display("[TB] error run");
    doStart();
    for (int k = 0; k < 4; k++) ackStage(k, 1'b0);
    enterCheck("err_entry", 4);
    tick();
    applyStimulus(1'b0, 1'b0, N'(1) << 4, N'(1) << 4, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("err_state", 32'(state_reg), 32'd15);
    checkOutput("err_flag", 32'(error), 32'd1);
    checkOutput("err_stage", 32'(err_stage), 32'd4);
    checkOutput("err_busy", 32'(stage_busy), 32'd0);
    checkOutput("err_start", 32'(stage_start), 32'd0);
    applyStimulus(1'b1, 1'b0, '1, '1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      tick();
      checkOutput("err_sticky_state", 32'(state_reg), 32'd15);
      checkOutput("err_sticky_flag", 32'(error), 32'd1);
    end
    checkOutput("err_sticky_stage", 32'(err_stage), 32'd4);
    doRestart();
    checkOutput("err_restart_state", 32'(state_reg), 32'd0);
    checkOutput("err_restart_flag", 32'(error), 32'd0);
    checkOutput("err_restart_stage", 32'(err_stage), 32'd0);

    // restart_en and stage_done[2] in the same cycle: restart wins.
    $display("[TB] restart mid-run");
    doStart();
    ackStage(0, 1'b0);
    ackStage(1, 1'b0);
    enterCheck("rsmid_entry", 2);
    tick();
    applyStimulus(1'b1, 1'b1, N'(1) << 2, '0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("rsmid_state", 32'(state_reg), 32'd0);
    checkOutput("rsmid_busy", 32'(stage_busy), 32'd0);
    checkOutput("rsmid_start", 32'(stage_start), 32'd0);
    tick();
    tick();
    checkOutput("rsmid_idle_state", 32'(state_reg), 32'd0);
    checkOutput("rsmid_pulse_count", 32'(pulse_log.size()), 32'd3);

    // stage_done held high: one stage per two cycles, none skipped.
    $display("[TB] stale done");
    pulse_log.delete();
    applyStimulus(1'b1, 1'b0, '1, '0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '1, '0, 1'b0);
    for (int k = 0; k < N; k++) begin
      enterCheck("stale", k);
      tick();
      checkOutput("stale_hold_state", 32'(state_reg), 32'(k + 1));
      tick();
    end
    checkOutput("stale_done_state", 32'(state_reg), 32'd8);
    checkOutput("stale_finished", 32'(finished_signal), 32'd1);
    checkOutput("stale_pulse_count", 32'(pulse_log.size()), 32'd7);
    for (int i = 0; i < 7 && i < pulse_log.size(); i++)
      checkOutput("stale_pulse_order", 32'(pulse_log[i]), 32'(i));
    doRestart();

    // Loop forever through stage 3: 255 loops allowed, the 256th faults.
    $display("[TB] loop saturation");
    doStart();
    checkOutput("sat_first_state", 32'(state_reg), 32'd1);
    ackStage(0, 1'b0);
    for (int r = 0; r < 256; r++) begin
      for (int k = 1; k <= 3; k++) begin
        checkOutput("sat_state", 32'(state_reg), 32'(k + 1));
        if (k == 3) checkOutput("sat_loop_count", 32'(loop_count), 32'(r));
        ackStage(k, k == 3);
      end
    end
    checkOutput("sat_err_state", 32'(state_reg), 32'd15);
    checkOutput("sat_err_flag", 32'(error), 32'd1);
    checkOutput("sat_err_stage", 32'(err_stage), 32'd3);
    checkOutput("sat_loop_count_final", 32'(loop_count), 32'd255);
    doRestart();

    // Reset in the middle of a run overrides everything.
    $display("[TB] reset mid-run");
    doStart();
    ackStage(0, 1'b0);
    nrst = 1'b0;
    applyStimulus(1'b1, 1'b0, '1, '0, 1'b1);
    tick();
    checkOutput("rstmid_state", 32'(state_reg), 32'd0);
    checkOutput("rstmid_busy", 32'(stage_busy), 32'd0);
    checkOutput("rstmid_start", 32'(stage_start), 32'd0);
    nrst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    checkOutput("rstmid_idle_state", 32'(state_reg), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
